// File: rtl/decode_stage_hz.sv
// Decode stage: instruction decode, integer register file with write-back
// bypass, load-use hazard detection and the registered ID/EX boundary.
module decode_stage_hz #(
  parameter int unsigned XLEN   = 64,
  parameter bit          BYPASS = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ValidD,
  input  logic [31:0]     InstrD,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] PCPlus4D,
  input  logic            RegWriteEnW,
  input  logic [4:0]      RDW,
  input  logic [XLEN-1:0] ResultW,
  input  logic            FlushE,
  output logic            StallD,
  output logic            PCSF,
  output logic [XLEN-1:0] PCTargetD,
  output logic            ValidE,
  output logic            RegWriteEnE,
  output logic            MemtoRegE,
  output logic            JALE,
  output logic            JALRE,
  output logic            BranchE,
  output logic            MemReadEnE,
  output logic            MemWriteEnE,
  output logic            ALUSrcE,
  output logic            IllegalE,
  output logic            Funct7bE,
  output logic [1:0]      ALUOpE,
  output logic [2:0]      Funct3E,
  output logic [1:0]      MemSizeE,
  output logic            LoadUnsignedE,
  output logic [4:0]      RdE,
  output logic [4:0]      Rs1E,
  output logic [4:0]      Rs2E,
  output logic [XLEN-1:0] ImmE,
  output logic [XLEN-1:0] PCE,
  output logic [XLEN-1:0] PCPlus4E,
  output logic [XLEN-1:0] ReadData1E,
  output logic [XLEN-1:0] ReadData2E
);

  localparam int unsigned NREGS = 32;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  logic [6:0]      opcode;
  logic [4:0]      rd;
  logic [4:0]      rs1_raw;
  logic [4:0]      rs2;
  logic [4:0]      rs1;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  logic            d_regwrite, d_memtoreg, d_jal, d_jalr, d_branch;
  logic            d_memread, d_memwrite, d_alusrc, d_illegal, d_lui;
  logic            d_use1, d_use2, d_funct7b;
  logic [1:0]      d_aluop;
  logic [2:0]      d_funct3;
  logic [XLEN-1:0] d_imm;

  logic [XLEN-1:0] rf [NREGS];
  logic            wr_hit;
  logic [XLEN-1:0] rd1, rd2;
  logic            bubble;

  assign opcode  = InstrD[6:0];
  assign rd      = InstrD[11:7];
  assign rs1_raw = InstrD[19:15];
  assign rs2     = InstrD[24:20];
  assign rs1     = d_lui ? 5'd0 : rs1_raw;

  assign imm_i = XLEN'($signed(InstrD[31:20]));
  assign imm_s = XLEN'($signed({InstrD[31:25], InstrD[11:7]}));
  assign imm_b = XLEN'($signed({InstrD[31], InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({InstrD[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({InstrD[31], InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0}));

  // Opcode decode; an unsupported opcode leaves every control bit cleared.
  always_comb begin
    d_regwrite = 1'b0;
    d_memtoreg = 1'b0;
    d_jal      = 1'b0;
    d_jalr     = 1'b0;
    d_branch   = 1'b0;
    d_memread  = 1'b0;
    d_memwrite = 1'b0;
    d_alusrc   = 1'b0;
    d_illegal  = 1'b0;
    d_lui      = 1'b0;
    d_use1     = 1'b0;
    d_use2     = 1'b0;
    d_aluop    = 2'b00;
    d_imm      = '0;
    case (opcode)
      OP_R: begin
        d_regwrite = 1'b1;
        d_aluop    = 2'b10;
        d_use1     = 1'b1;
        d_use2     = 1'b1;
      end
      OP_I: begin
        d_regwrite = 1'b1;
        d_aluop    = 2'b11;
        d_alusrc   = 1'b1;
        d_use1     = 1'b1;
        d_imm      = imm_i;
      end
      OP_LOAD: begin
        d_regwrite = 1'b1;
        d_memtoreg = 1'b1;
        d_memread  = 1'b1;
        d_alusrc   = 1'b1;
        d_use1     = 1'b1;
        d_imm      = imm_i;
      end
      OP_STORE: begin
        d_memwrite = 1'b1;
        d_alusrc   = 1'b1;
        d_use1     = 1'b1;
        d_use2     = 1'b1;
        d_imm      = imm_s;
      end
      OP_BRANCH: begin
        d_branch   = 1'b1;
        d_aluop    = 2'b01;
        d_use1     = 1'b1;
        d_use2     = 1'b1;
        d_imm      = imm_b;
      end
      OP_JAL: begin
        d_regwrite = 1'b1;
        d_jal      = 1'b1;
        d_imm      = imm_j;
      end
      OP_JALR: begin
        d_regwrite = 1'b1;
        d_jalr     = 1'b1;
        d_alusrc   = 1'b1;
        d_use1     = 1'b1;
        d_imm      = imm_i;
      end
      OP_LUI: begin
        d_regwrite = 1'b1;
        d_alusrc   = 1'b1;
        d_lui      = 1'b1;
        d_imm      = imm_u;
      end
      default: d_illegal = 1'b1;
    endcase
  end

  assign d_funct3  = d_illegal ? 3'b000 : InstrD[14:12];
  assign d_funct7b = d_illegal ? 1'b0   : InstrD[30];

  // Register file reads; x0 is hard-wired to zero.
  assign wr_hit = RegWriteEnW && (RDW != 5'd0);
  assign rd1 = (rs1 == 5'd0) ? '0 :
               (BYPASS && wr_hit && (RDW == rs1)) ? ResultW : rf[rs1];
  assign rd2 = (rs2 == 5'd0) ? '0 :
               (BYPASS && wr_hit && (RDW == rs2)) ? ResultW : rf[rs2];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else if (wr_hit) begin
      rf[RDW] <= ResultW;
    end
  end

  // Load in execute whose destination is a used source of decode: one bubble.
  assign StallD = ValidD && ValidE && MemReadEnE && (RdE != 5'd0) &&
                  ((d_use1 && (rs1 == RdE)) || (d_use2 && (rs2 == RdE))) && !FlushE;
  assign PCSF      = ValidD && (opcode == OP_JAL) && !FlushE && !StallD;
  assign PCTargetD = PCD + d_imm;

  // Reset, flush, stall and an empty IF/ID all load a zeroed bubble.
  assign bubble = !rst || FlushE || StallD || !ValidD;

  always_ff @(posedge clk) begin
    if (bubble) begin
      ValidE        <= 1'b0;
      RegWriteEnE   <= 1'b0;
      MemtoRegE     <= 1'b0;
      JALE          <= 1'b0;
      JALRE         <= 1'b0;
      BranchE       <= 1'b0;
      MemReadEnE    <= 1'b0;
      MemWriteEnE   <= 1'b0;
      ALUSrcE       <= 1'b0;
      IllegalE      <= 1'b0;
      Funct7bE      <= 1'b0;
      ALUOpE        <= 2'b00;
      Funct3E       <= 3'b000;
      MemSizeE      <= 2'b00;
      LoadUnsignedE <= 1'b0;
      RdE           <= 5'd0;
      Rs1E          <= 5'd0;
      Rs2E          <= 5'd0;
      ImmE          <= '0;
      PCE           <= '0;
      PCPlus4E      <= '0;
      ReadData1E    <= '0;
      ReadData2E    <= '0;
    end else begin
      ValidE        <= ValidD;
      RegWriteEnE   <= d_regwrite;
      MemtoRegE     <= d_memtoreg;
      JALE          <= d_jal;
      JALRE         <= d_jalr;
      BranchE       <= d_branch;
      MemReadEnE    <= d_memread;
      MemWriteEnE   <= d_memwrite;
      ALUSrcE       <= d_alusrc;
      IllegalE      <= d_illegal;
      Funct7bE      <= d_funct7b;
      ALUOpE        <= d_aluop;
      Funct3E       <= d_funct3;
      MemSizeE      <= d_funct3[1:0];
      LoadUnsignedE <= d_funct3[2];
      RdE           <= rd;
      Rs1E          <= rs1;
      Rs2E          <= rs2;
      ImmE          <= d_imm;
      PCE           <= PCD;
      PCPlus4E      <= PCPlus4D;
      ReadData1E    <= rd1;
      ReadData2E    <= rd2;
    end
  end

endmodule

// File: tb/tb_decode_stage_hz.sv
// Bench for decode_stage_hz: directed cases plus random instruction streams
// checked against a behavioural decode/regfile model.
module tb_decode_stage_hz;

  logic        clk = 1'b0;
  logic        rst, ValidD, RegWriteEnW, FlushE;
  logic [31:0] InstrD;
  logic [63:0] PCD, PCPlus4D, ResultW;
  logic [4:0]  RDW;

  logic        StallD, PCSF, ValidE, RegWriteEnE, MemtoRegE, JALE, JALRE, BranchE;
  logic        MemReadEnE, MemWriteEnE, ALUSrcE, IllegalE, Funct7bE, LoadUnsignedE;
  logic [1:0]  ALUOpE, MemSizeE;
  logic [2:0]  Funct3E;
  logic [4:0]  RdE, Rs1E, Rs2E;
  logic [63:0] PCTargetD, ImmE, PCE, PCPlus4E, ReadData1E, ReadData2E;

  logic        nb_StallD, nb_PCSF, nb_ValidE, nb_RegWriteEnE, nb_MemtoRegE, nb_JALE, nb_JALRE;
  logic        nb_BranchE, nb_MemReadEnE, nb_MemWriteEnE, nb_ALUSrcE, nb_IllegalE, nb_Funct7bE;
  logic        nb_LoadUnsignedE;
  logic [1:0]  nb_ALUOpE, nb_MemSizeE;
  logic [2:0]  nb_Funct3E;
  logic [4:0]  nb_RdE, nb_Rs1E, nb_Rs2E;
  logic [63:0] nb_PCTargetD, nb_ImmE, nb_PCE, nb_PCPlus4E, nb_ReadData1E, nb_ReadData2E;

  always #5 clk = ~clk;

  decode_stage_hz #(.XLEN(64), .BYPASS(1'b1)) dut (
    .clk(clk), .rst(rst), .ValidD(ValidD), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .RegWriteEnW(RegWriteEnW), .RDW(RDW), .ResultW(ResultW), .FlushE(FlushE),
    .StallD(StallD), .PCSF(PCSF), .PCTargetD(PCTargetD), .ValidE(ValidE),
    .RegWriteEnE(RegWriteEnE), .MemtoRegE(MemtoRegE), .JALE(JALE), .JALRE(JALRE),
    .BranchE(BranchE), .MemReadEnE(MemReadEnE), .MemWriteEnE(MemWriteEnE), .ALUSrcE(ALUSrcE),
    .IllegalE(IllegalE), .Funct7bE(Funct7bE), .ALUOpE(ALUOpE), .Funct3E(Funct3E),
    .MemSizeE(MemSizeE), .LoadUnsignedE(LoadUnsignedE), .RdE(RdE), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .ImmE(ImmE), .PCE(PCE), .PCPlus4E(PCPlus4E), .ReadData1E(ReadData1E), .ReadData2E(ReadData2E)
  );

  decode_stage_hz #(.XLEN(64), .BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .ValidD(ValidD), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .RegWriteEnW(RegWriteEnW), .RDW(RDW), .ResultW(ResultW), .FlushE(FlushE),
    .StallD(nb_StallD), .PCSF(nb_PCSF), .PCTargetD(nb_PCTargetD), .ValidE(nb_ValidE),
    .RegWriteEnE(nb_RegWriteEnE), .MemtoRegE(nb_MemtoRegE), .JALE(nb_JALE), .JALRE(nb_JALRE),
    .BranchE(nb_BranchE), .MemReadEnE(nb_MemReadEnE), .MemWriteEnE(nb_MemWriteEnE),
    .ALUSrcE(nb_ALUSrcE), .IllegalE(nb_IllegalE), .Funct7bE(nb_Funct7bE), .ALUOpE(nb_ALUOpE),
    .Funct3E(nb_Funct3E), .MemSizeE(nb_MemSizeE), .LoadUnsignedE(nb_LoadUnsignedE),
    .RdE(nb_RdE), .Rs1E(nb_Rs1E), .Rs2E(nb_Rs2E), .ImmE(nb_ImmE), .PCE(nb_PCE),
    .PCPlus4E(nb_PCPlus4E), .ReadData1E(nb_ReadData1E), .ReadData2E(nb_ReadData2E)
  );

  logic [18:0] obs_ctrl, nb_ctrl;
  logic [14:0] obs_regs, nb_regs;
  assign obs_ctrl = {ValidE, RegWriteEnE, MemtoRegE, JALE, JALRE, BranchE, MemReadEnE, MemWriteEnE,
                     ALUSrcE, IllegalE, Funct7bE, ALUOpE, Funct3E, MemSizeE, LoadUnsignedE};
  assign nb_ctrl  = {nb_ValidE, nb_RegWriteEnE, nb_MemtoRegE, nb_JALE, nb_JALRE, nb_BranchE,
                     nb_MemReadEnE, nb_MemWriteEnE, nb_ALUSrcE, nb_IllegalE, nb_Funct7bE,
                     nb_ALUOpE, nb_Funct3E, nb_MemSizeE, nb_LoadUnsignedE};
  assign obs_regs = {RdE, Rs1E, Rs2E};
  assign nb_regs  = {nb_RdE, nb_Rs1E, nb_Rs2E};

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Model state: architectural register file and the previous ID/EX content.
  logic [63:0] rf_m [32];
  logic        pv = 1'b0, pm = 1'b0;
  logic [4:0]  prd = 5'd0;
  logic        obs_stall, obs_pcsf;

  logic [6:0] ops [11] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0000011, 7'b0100011,
                           7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111,
                           7'b1111111};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] mread(input logic [4:0] a, input logic byp, input logic we,
                                        input logic [4:0] rdw, input logic [63:0] resw);
    if (a == 5'd0) return 64'd0;
    if (byp && we && rdw != 5'd0 && rdw == a) return resw;
    return rf_m[a];
  endfunction

  // One cycle: drive at negedge, check combinational outputs, then ID/EX after the edge.
  task automatic step(input logic r, input logic v, input logic [31:0] ins, input logic [63:0] pc,
                      input logic fl, input logic we, input logic [4:0] rdw, input logic [63:0] resw);
    logic [6:0]  op;
    logic        is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr, is_lui, legal;
    logic        u1, u2, stall_m, pcsf_m, bub, f7b, rwe, asrc;
    logic [4:0]  rs1m;
    logic [1:0]  aluop;
    logic [2:0]  f3;
    longint      sx, s20, s25, s31;
    logic [63:0] imm;
    logic [18:0] e_ctrl;
    logic [14:0] e_regs;
    logic [63:0] e_rd1, e_rd2, e_nb1, e_nb2;

    rst = r; ValidD = v; InstrD = ins; PCD = pc; PCPlus4D = pc + 64'd4;
    FlushE = fl; RegWriteEnW = we; RDW = rdw; ResultW = resw;

    op = ins[6:0];
    is_r = (op == 7'b0110011); is_i = (op == 7'b0010011); is_ld = (op == 7'b0000011);
    is_st = (op == 7'b0100011); is_br = (op == 7'b1100011); is_jal = (op == 7'b1101111);
    is_jalr = (op == 7'b1100111); is_lui = (op == 7'b0110111);
    legal = is_r | is_i | is_ld | is_st | is_br | is_jal | is_jalr | is_lui;

    sx  = longint'($signed(ins));
    s20 = sx >>> 20;
    s25 = sx >>> 25;
    s31 = sx >>> 31;
    if (is_i || is_ld || is_jalr) imm = s20;
    else if (is_st) imm = (s25 << 5) | 64'(ins[11:7]);
    else if (is_br) imm = (s31 << 12) | (64'(ins[7]) << 11) | (64'(ins[30:25]) << 5) | (64'(ins[11:8]) << 1);
    else if (is_jal) imm = (s31 << 20) | (64'(ins[19:12]) << 12) | (64'(ins[20]) << 11) | (64'(ins[30:21]) << 1);
    else if (is_lui) imm = sx & ~64'hFFF;
    else imm = 64'd0;

    rs1m    = is_lui ? 5'd0 : ins[19:15];
    u1      = is_r | is_i | is_ld | is_st | is_br | is_jalr;
    u2      = is_r | is_st | is_br;
    stall_m = v && pv && pm && prd != 5'd0 &&
              ((u1 && rs1m == prd) || (u2 && ins[24:20] == prd)) && !fl;
    pcsf_m  = v && is_jal && !fl && !stall_m;

    #1;
    obs_stall = StallD;
    obs_pcsf  = PCSF;
    check("stall", 64'(StallD), 64'(stall_m));
    check("pcsf", 64'(PCSF), 64'(pcsf_m));
    check("target", PCTargetD, pc + imm);
    check("nb_stall", 64'(nb_StallD), 64'(stall_m));
    check("nb_pcsf", 64'(nb_PCSF), 64'(pcsf_m));
    check("nb_target", nb_PCTargetD, pc + imm);

    bub   = !r || fl || stall_m || !v;
    f3    = legal ? ins[14:12] : 3'b000;
    f7b   = legal ? ins[30] : 1'b0;
    aluop = is_br ? 2'b01 : is_r ? 2'b10 : is_i ? 2'b11 : 2'b00;
    rwe   = is_r | is_i | is_ld | is_jal | is_jalr | is_lui;
    asrc  = is_i | is_ld | is_st | is_jalr | is_lui;
    e_ctrl = bub ? 19'd0 : {1'b1, rwe, is_ld, is_jal, is_jalr, is_br, is_ld, is_st, asrc,
                            !legal, f7b, aluop, f3, f3[1:0], f3[2]};
    e_regs = {ins[11:7], rs1m, ins[24:20]};
    e_rd1  = mread(rs1m, 1'b1, we, rdw, resw);
    e_rd2  = mread(ins[24:20], 1'b1, we, rdw, resw);
    e_nb1  = mread(rs1m, 1'b0, we, rdw, resw);
    e_nb2  = mread(ins[24:20], 1'b0, we, rdw, resw);

    if (!r) for (int i = 0; i < 32; i++) rf_m[i] = 64'd0;
    else if (we && rdw != 5'd0) rf_m[rdw] = resw;

    @(posedge clk);
    #1;
    check("ctrl", 64'(obs_ctrl), 64'(e_ctrl));
    check("nb_ctrl", 64'(nb_ctrl), 64'(e_ctrl));
    if (!bub) begin
      check("regs", 64'(obs_regs), 64'(e_regs));
      check("imm", ImmE, imm);
      check("pc", PCE, pc);
      check("pc4", PCPlus4E, pc + 64'd4);
      check("rd1", ReadData1E, e_rd1);
      check("rd2", ReadData2E, e_rd2);
      check("nb_regs", 64'(nb_regs), 64'(e_regs));
      check("nb_imm", nb_ImmE, imm);
      check("nb_pc", nb_PCE, pc);
      check("nb_pc4", nb_PCPlus4E, pc + 64'd4);
      check("nb_rd1", nb_ReadData1E, e_nb1);
      check("nb_rd2", nb_ReadData2E, e_nb2);
    end
    pv  = !bub;
    pm  = !bub && is_ld;
    prd = bub ? 5'd0 : ins[11:7];
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] ins;
    logic [63:0] pc;
    rst = 1'b0; ValidD = 1'b0; InstrD = 32'd0; PCD = 64'd0; PCPlus4D = 64'd0;
    RegWriteEnW = 1'b0; RDW = 5'd0; ResultW = 64'd0; FlushE = 1'b0;
    @(negedge clk);

    step(1'b0, 1'b0, 32'd0, 64'd0, 1'b0, 1'b0, 5'd0, 64'd0);
    check("rst_valid", 64'(ValidE), 64'd0);
    check("rst_imm", ImmE, 64'd0);

    // lb x1,1(x0)
    step(1'b1, 1'b1, 32'h00100083, 64'h40, 1'b0, 1'b0, 5'd0, 64'd0);
    check("ld_imm", ImmE, 64'd1);
    check("ld_rd", 64'(RdE), 64'd1);
    check("ld_ctl", 64'({ValidE, MemReadEnE, RegWriteEnE, MemtoRegE, MemSizeE}), 64'b111100);

    // beq x2,x4,+6
    step(1'b1, 1'b1, 32'h00410363, 64'h40, 1'b0, 1'b0, 5'd0, 64'd0);
    check("br_ctl", 64'({BranchE, ALUOpE, RegWriteEnE}), 64'b1010);
    check("br_imm", ImmE, 64'd6);
    check("br_tgt", PCTargetD, 64'h46);

    // jal x1,+0x800
    step(1'b1, 1'b1, 32'h001000EF, 64'h40, 1'b0, 1'b0, 5'd0, 64'd0);
    check("jal_pcsf", 64'(obs_pcsf), 64'd1);
    check("jal_tgt", PCTargetD, 64'h840);
    check("jal_e", 64'({JALE, RdE}), 64'b1_00001);
    check("jal_pc4", PCPlus4E, 64'h44);

    step(1'b1, 1'b1, 32'h001000EF, 64'hFFFF_FFFF_FFFF_FC00, 1'b0, 1'b0, 5'd0, 64'd0);
    check("wrap_tgt", PCTargetD, 64'h400);

    // add x3,x1,x0 with a same-cycle write of x1
    step(1'b1, 1'b1, 32'h000081B3, 64'h50, 1'b0, 1'b1, 5'd1, 64'h1234);
    check("byp_rd1", ReadData1E, 64'h1234);
    check("nobyp_rd1", nb_ReadData1E, 64'd0);
    step(1'b1, 1'b1, 32'h000081B3, 64'h54, 1'b0, 1'b0, 5'd0, 64'd0);
    check("byp_rd1_next", ReadData1E, 64'h1234);
    check("nobyp_rd1_next", nb_ReadData1E, 64'h1234);

    // lw x5,0(x0); add x6,x5,x5
    step(1'b1, 1'b1, 32'h00002283, 64'h60, 1'b0, 1'b0, 5'd0, 64'd0);
    step(1'b1, 1'b1, 32'h00528333, 64'h64, 1'b0, 1'b0, 5'd0, 64'd0);
    check("lu_stall", 64'(obs_stall), 64'd1);
    check("lu_bubble", 64'(ValidE), 64'd0);
    step(1'b1, 1'b1, 32'h00528333, 64'h64, 1'b0, 1'b0, 5'd0, 64'd0);
    check("lu_stall_drop", 64'(obs_stall), 64'd0);
    check("lu_issue", 64'({ValidE, RdE}), 64'b1_00110);

    // reset during a load-use stall
    step(1'b1, 1'b1, 32'h00002283, 64'h60, 1'b0, 1'b0, 5'd0, 64'd0);
    step(1'b0, 1'b1, 32'h00528333, 64'h64, 1'b0, 1'b0, 5'd0, 64'd0);
    check("rst_stall_bubble", 64'(obs_ctrl), 64'd0);
    step(1'b1, 1'b1, 32'h00528333, 64'h64, 1'b0, 1'b0, 5'd0, 64'd0);
    check("rst_stall_issue", 64'(ValidE), 64'd1);

    // flush with JAL in decode
    step(1'b1, 1'b1, 32'h001000EF, 64'h40, 1'b1, 1'b0, 5'd0, 64'd0);
    check("fl_pcsf", 64'(obs_pcsf), 64'd0);
    check("fl_bubble", 64'(ValidE), 64'd0);

    step(1'b1, 1'b1, 32'hFFFF_FFFF, 64'h70, 1'b0, 1'b0, 5'd0, 64'd0);
    check("ill_ctl", 64'(obs_ctrl), 64'h40200);

    // reset also ignores the write port and clears the register file
    step(1'b1, 1'b1, 32'h000081B3, 64'h74, 1'b0, 1'b1, 5'd2, 64'h55);
    step(1'b0, 1'b1, 32'h000081B3, 64'h78, 1'b0, 1'b1, 5'd1, 64'hDEAD);
    check("rst2_ctrl", 64'(obs_ctrl), 64'd0);
    check("rst2_data", ReadData1E | ReadData2E | ImmE | PCE | PCPlus4E | 64'(obs_regs), 64'd0);
    step(1'b1, 1'b1, 32'h000081B3, 64'h7C, 1'b0, 1'b0, 5'd0, 64'd0);
    check("rst2_rf", ReadData1E, 64'd0);

    for (int n = 0; n < 3000; n++) begin
      ins = $urandom;
      ins[6:0]   = ops[$urandom_range(0, 10)];
      ins[11:7]  = 5'($urandom_range(0, 7));
      ins[19:15] = 5'($urandom_range(0, 7));
      ins[24:20] = 5'($urandom_range(0, 7));
      pc = {$urandom, $urandom};
      if ($urandom_range(0, 15) == 0) pc = 64'hFFFF_FFFF_FFFF_F000 | 64'($urandom_range(0, 4095));
      pc[1:0] = 2'b00;
      step($urandom_range(0, 63) != 0, $urandom_range(0, 7) != 0, ins, pc,
           $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1,
           5'($urandom_range(0, 7)), {$urandom, $urandom});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/decode_stage_hz.md
# decode_stage_hz

Parametrised decode stage for the pipelined RISC-V core. It decodes the instruction held in IF/ID and owns the integer register file, including write-back bypass. It contains the registered ID/EX pipeline boundary. Over the current decode stage it adds an XLEN parameter, valid tracking, load-use hazard detection with bubble insertion, external flush, JALR support and illegal-instruction flagging. Sits between fetch (IF/ID register) and the execute stage.

## Interface
- XLEN, 64, datapath width (32 or 64); PC, immediates and registers are XLEN wide.
- BYPASS, 1, 1 = same-cycle write-back value is forwarded to decode reads; 0 = read the array only.
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  synchronous, active-low reset (rst==0 at a rising edge resets).
- ValidD  in  1  IF/ID holds a real instruction.
- InstrD  in  32  instruction word.
- PCD, PCPlus4D  in  XLEN  instruction PC and PC+4.
- RegWriteEnW  in  1, RDW  in  5, ResultW  in  XLEN  write-back port.
- FlushE  in  1  execute redirect; squashes the instruction in decode.
- StallD  out  1  combinational; hold PC and IF/ID.
- PCSF  out  1  combinational; JAL redirect.
- PCTargetD  out  XLEN  combinational; PCD + ImmD.
- ID/EX outputs, all registered:
  - ValidE, RegWriteEnE, MemtoRegE, JALE, JALRE, BranchE, MemReadEnE, MemWriteEnE, ALUSrcE, IllegalE, Funct7bE  1 each.
  - ALUOpE 2, Funct3E 3, MemSizeE 2, LoadUnsignedE 1.
  - RdE, Rs1E, Rs2E 5 each.
  - ImmE, PCE, PCPlus4E, ReadData1E, ReadData2E  XLEN each.

## Operation
- **Supported opcodes:** R 0110011, I-ALU 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111. Any other opcode is illegal.
- **ALUOpE:** 00 add (LOAD/STORE/JAL/JALR/LUI), 01 branch compare, 10 R-type, 11 I-ALU.
- **ALUSrcE:** 1 for I-ALU/LOAD/STORE/JALR/LUI.
- **RegWriteEnE:** R/I/LOAD/JAL/JALR/LUI.
- **Memory controls:** MemtoRegE only for LOAD. MemSizeE = funct3[1:0]; LoadUnsignedE = funct3[2].
- **LUI:** Rs1E forced to 0.
- **Immediates:** I/S/B/U/J formats, sign-extended from instr[31] to XLEN. U-format is imm[31:12]<<12, sign-extended.
- **Register file:** 32×XLEN. x0 always reads 0 and ignores writes. Write on rising edge when RegWriteEnW && RDW!=0.
- **Read bypass (BYPASS=1):** if RegWriteEnW && RDW!=0 && RDW==rs, the read returns ResultW.
- **Source-usage flags:**
  - rs1 used by R, I-ALU, LOAD, STORE, BRANCH, JALR.
  - rs2 used by R, STORE, BRANCH.
  - Unused fields never cause hazards.
- **Load-use hazard:** StallD = ValidD & ValidE & MemReadEnE & RdE!=0 & ((rs1 used & Rs1==RdE) | (rs2 used & Rs2==RdE)) & ~FlushE.
- **PCSF:** ValidD & opcode==JAL & ~FlushE & ~StallD.
- **Illegal instruction:** all control bits 0, ValidE=1, IllegalE=1, PCSF=0.

## Timing
- **ID/EX update priority at each rising edge:**
  1. rst==0 → every registered output 0; register file cleared to 0; write port ignored.
  2. FlushE → bubble.
  3. StallD → bubble.
  4. else capture decode results; ValidE = ValidD.
- **Bubble:** ValidE and all control/enable bits 0. Data fields don't-care; RTL drives 0.
- **Latency:** decode-to-E outputs 1 cycle. PCSF/PCTargetD/StallD are combinational, same cycle.
- **Stall length:** a load-use stall lasts exactly 1 cycle. The next cycle ValidE=0, so StallD drops.
- **Write/read same cycle:** with BYPASS=0, a decode read of a register written this edge returns the old value.
- **Reset mid-stall or mid-flush:** reset wins; the next cycle starts from bubble state.
- **Width arithmetic:** PCTargetD is modulo 2^XLEN; overflow wraps.

## Test plan
- **Load:** reset low 1 cycle, then InstrD=0x00100083 (lb x1,1(x0)), PCD=0x40 → next edge ImmE=1, RdE=1, MemReadEnE=RegWriteEnE=MemtoRegE=1, MemSizeE=00, ValidE=1.
- **Branch:** InstrD=0x00410363 (beq x2,x4,+6) → BranchE=1, ALUOpE=01, RegWriteEnE=0, ImmE=6, PCTargetD=0x46 combinationally.
- **JAL:** InstrD=0x001000EF, PCD=0x40, PCPlus4D=0x44 → PCSF=1 and PCTargetD=0x840 same cycle; next edge JALE=1, RdE=1, PCPlus4E=0x44.
- **Write-back bypass:** RegWriteEnW=1, RDW=1, ResultW=0x1234 with add x3,x1,x0 in decode → ReadData1E=0x1234 (BYPASS=1). Same stimulus with BYPASS=0 → ReadData1E=0. Following cycle → 0x1234 in both.
- **Load-use:** lw x5,0(x0), then add x6,x5,x5 → StallD=1 for one cycle, ID/EX bubble (ValidE=0), then add issues with RdE=6. Separately, FlushE=1 during a JAL in decode → PCSF=0 and a bubble.
- **Illegal and reset:** InstrD=0xFFFFFFFF → IllegalE=1, all control bits 0. Then rst=0 for one edge → every output 0; registers read 0.
